// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: itype codes, FSM states,
// source indices and the one-hot-to-code helper.
package irq_pkg;

  localparam int NSRC     = 3;
  localparam int SRC_GPIO = 0;
  localparam int SRC_UART = 1;
  localparam int SRC_TIM1 = 2;

  typedef enum logic [3:0] {
    ITYPE_EXE  = 4'b0000,
    ITYPE_GPIO = 4'b0011,
    ITYPE_UART = 4'b0100,
    ITYPE_TIM1 = 4'b0101
  } itype_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_SERVICE
  } state_e;

  function automatic itype_e code_of(input logic [NSRC-1:0] oh);
    itype_e code;
    code = ITYPE_EXE;
    if (oh[SRC_GPIO])      code = ITYPE_GPIO;
    else if (oh[SRC_UART]) code = ITYPE_UART;
    else if (oh[SRC_TIM1]) code = ITYPE_TIM1;
    return code;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Periodic TIM1 event source: down-counter reloaded from i_tim_reload,
// one-cycle event each time it reaches zero; a zero reload parks it silently.
module irq_timer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_tim_reload,
  output logic        o_event
);

  logic [15:0] r_count;
  logic        w_zero;

  assign w_zero  = (r_count == 16'd0);
  assign o_event = w_zero && (i_tim_reload != 16'd0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_count <= 16'd0;
    else if (w_zero)
      r_count <= i_tim_reload;
    else
      r_count <= r_count - 16'd1;
  end

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter (GPIO > UART > TIM1) with offer/ack handshake.
// Define IRQ_TIMER_EN to replace the external tim1_req with the internal irq_timer.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_gpio_req,
  input  logic        i_uart_req,
  input  logic        i_tim1_req,
  input  logic [15:0] i_tim_reload,
  input  logic [2:0]  i_irq_en,
  input  logic [2:0]  i_tick,
  input  logic        i_cpu_i,
  output logic [3:0]  o_itype,
  output logic [2:0]  o_pending
);

  state_e          r_state, w_state_next;
  itype_e          r_itype, w_itype_next;
  logic [NSRC-1:0] r_req_prev, r_pending, r_src_oh;
  logic            r_armed, r_cpu_prev, r_tick_zero;
  logic [NSRC-1:0] w_req, w_req_evt, w_src_evt, w_offer, w_win, w_clr;
  logic            w_cpu_rise, w_ack, w_src_en, w_unused;

  assign w_req     = {i_tim1_req, i_uart_req, i_gpio_req};
  // r_armed masks the first edge after reset so a request already high is not an event
  assign w_req_evt = w_req & ~r_req_prev & {NSRC{r_armed}};

`ifdef IRQ_TIMER_EN
  logic w_tim_evt;

  irq_timer u_timer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_tim_reload (i_tim_reload),
    .o_event      (w_tim_evt)
  );

  assign w_src_evt = {w_tim_evt, w_req_evt[SRC_UART], w_req_evt[SRC_GPIO]};
  assign w_unused  = w_req_evt[SRC_TIM1];
`else
  assign w_src_evt = w_req_evt;
  assign w_unused  = ^i_tim_reload;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_req_prev  <= '0;
      r_armed     <= 1'b0;
      r_cpu_prev  <= 1'b0;
      r_tick_zero <= 1'b0;
    end else begin
      r_req_prev  <= w_req;
      r_armed     <= 1'b1;
      r_cpu_prev  <= i_cpu_i;
      r_tick_zero <= (i_tick == 3'd0);
    end
  end

  // Set beats clear so an event coinciding with its own acknowledge survives
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pending
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
          r_pending[gi] <= 1'b0;
        else
          r_pending[gi] <= (r_pending[gi] & ~w_clr[gi]) | (w_src_evt[gi] & i_irq_en[gi]);
      end
    end
  endgenerate

  assign w_offer    = r_pending & i_irq_en;
  assign w_win      = w_offer & (~w_offer + 3'd1);
  assign w_cpu_rise = i_cpu_i & ~r_cpu_prev;
  assign w_ack      = w_cpu_rise & r_tick_zero;
  assign w_src_en   = |(r_src_oh & i_irq_en);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_itype  <= ITYPE_EXE;
      r_src_oh <= '0;
    end else begin
      r_state <= w_state_next;
      r_itype <= w_itype_next;
      if (r_state == ST_IDLE && w_state_next == ST_OFFER)
        r_src_oh <= w_win;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_rise)
          w_state_next = ST_SERVICE;
        else if (!i_cpu_i && (|w_offer))
          w_state_next = ST_OFFER;
      end
      ST_OFFER: begin
        if (!w_src_en)
          w_state_next = ST_IDLE;
        else if (w_ack)
          w_state_next = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (!i_cpu_i)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_itype_next = ITYPE_EXE;
    w_clr        = '0;
    if (r_state == ST_IDLE && w_state_next == ST_OFFER)
      w_itype_next = code_of(w_win);
    else if (r_state == ST_OFFER && w_state_next == ST_OFFER)
      w_itype_next = code_of(r_src_oh);
    else if (r_state == ST_OFFER && w_state_next == ST_SERVICE)
      w_clr = r_src_oh;
  end

  assign o_itype   = r_itype;
  assign o_pending = r_pending;

endmodule
